// File: rtl/uart_tx_fifo_if.sv
// Host/serializer handshake bundle for uart_tx_fifo: write port, launch port and status.
// The host side (master) drives writes and the completion tick; the FIFO (slave) drives the rest.
interface uart_tx_fifo_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              tx_done_tick;
  logic              tx_start;
  logic [DATA_W-1:0] tx_din;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;

  modport master (
    output wr_en, wr_data, tx_done_tick,
    input  tx_start, tx_din, full, empty, count, overflow
  );

  modport slave (
    input  wr_en, wr_data, tx_done_tick,
    output tx_start, tx_din, full, empty, count, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding uart_tx: buffers host bytes in a circular store and launches them
// one at a time, waiting for the serializer's done tick between launches.
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_fifo_if.slave  bus
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wp_q, wp_d;
  logic [ADDR_W-1:0] rp_q, rp_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              tx_start_q, tx_start_d;
  logic [DATA_W-1:0] tx_din_q, tx_din_d;
  logic              overflow_q, overflow_d;

  logic full, empty, wr_acc, pop;

  // Flags come from the registered count, so a same-cycle pop never frees a slot early.
  assign full   = (count_q == FULL_CNT);
  assign empty  = (count_q == '0);
  assign wr_acc = bus.wr_en && !full;
  assign pop    = (state_q == S_IDLE) && !empty;

  always_comb begin
    state_d    = state_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    tx_start_d = 1'b0;
    tx_din_d   = tx_din_q;
    overflow_d = bus.wr_en && full;

    if (wr_acc) begin
      wp_d = wp_q + ADDR_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          tx_din_d   = mem[rp_q];
          rp_d       = rp_q + ADDR_W'(1);
          tx_start_d = 1'b1;
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        if (bus.tx_done_tick) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    unique case ({wr_acc, pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      tx_start_q <= 1'b0;
      tx_din_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      tx_start_q <= tx_start_d;
      tx_din_q   <= tx_din_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wp_q] <= bus.wr_data;
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_din   = tx_din_q;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side buffer and launch controller that sits directly upstream of `uart_tx`. It accepts bytes from the host at clock rate into a circular FIFO and hands them to the transmitter one at a time. To launch a byte it drives `tx_start` and `tx_din`, then waits for `tx_done_tick` before launching the next. This decouples bursty producers from the baud-rate-limited serial line.

## Interface
- `data_bits`, 8: width of each entry; must match `uart_tx` `data_bits`.
- `addr_bits`, 4: FIFO address width; depth = 2^`addr_bits` (16 by default).

- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  **asynchronous, active-high reset.**
- `wr_en`  in  1  host write strobe, one byte per cycle while high.
- `wr_data`  in  `data_bits`  byte to enqueue; sampled when `wr_en`=1.
- `tx_done_tick`  in  1  one-cycle completion pulse from `uart_tx`.
- `tx_start`  out  1  one-cycle launch pulse to `uart_tx`; registered.
- `tx_din`  out  `data_bits`  byte being launched; registered, valid with `tx_start` and held until the next launch.
- `full`  out  1  `count` == 2^`addr_bits`.
- `empty`  out  1  `count` == 0.
- `count`  out  `addr_bits`+1  number of stored entries (0..2^`addr_bits`).
- `overflow`  out  1  one-cycle pulse when a write is dropped.

## Operation
- **Storage**
  - Circular buffer of 2^`addr_bits` entries with write pointer `wp` and read pointer `rp`, each `addr_bits` wide.
  - Both pointers wrap naturally from 2^`addr_bits`-1 to 0.
  - `count` is a separate `addr_bits`+1-bit register. `full` and `empty` are derived from the registered `count` only.
- **Write**
  - Accepted iff `wr_en`=1 and `full`=0. This decision uses the registered `full`, even if a pop occurs in the same cycle.
  - On acceptance: `mem[wp]`<=`wr_data`, `wp`<=`wp`+1.
  - If `wr_en`=1 and `full`=1: no storage change, and `overflow`=1 on the next cycle.
- **Launch FSM**, two states:
  - **IDLE**: if `empty`=0, then pop: `tx_din`<=`mem[rp]`, `rp`<=`rp`+1, `tx_start`<=1, go to BUSY. Otherwise stay in IDLE.
  - **BUSY**: `tx_start`<=0. On `tx_done_tick`=1, go to IDLE. Otherwise stay.
  - `tx_done_tick` received in IDLE is ignored.
- **Count update**
  - Write only: +1.
  - Pop only: -1.
  - Both in the same cycle: unchanged.
  - Neither: unchanged.
- **Arithmetic**: `count` can never exceed 2^`addr_bits` or drop below 0, because writes are gated by `full` and pops by `empty`.

## Timing
- **Reset values** (immediate on `reset`=1, independent of `clk`):
  - `wp`=`rp`=0, `count`=0.
  - `empty`=1, `full`=0.
  - `tx_start`=0, `tx_din`=0, `overflow`=0.
  - State = IDLE. Memory contents are don't-care.
- **Write-to-launch latency**: write into an empty FIFO at edge N gives `count`=1 / `empty`=0 after N, then `tx_start`=1 with `tx_din` valid after edge N+1. That is 2 cycles.
- **Launch-to-launch**: `tx_done_tick` sampled at edge M puts the FSM in IDLE after M. If the FIFO is non-empty, `tx_start` rises after M+1. `uart_tx` is idle by then.
- **`tx_start` width**: exactly one cycle per byte. It never asserts while the FSM is in BUSY.
- **`tx_din` stability**: stable from the `tx_start` cycle until the next pop.
- **Flag timing**: `full`/`empty` update one cycle after the write or pop that changes `count`.
- **Reset mid-transmission**: FIFO is flushed and the FSM returns to IDLE. The serializer's late `tx_done_tick` is ignored in IDLE.
- **Ordering**: bytes leave in strict write order across pointer wrap-around.

## Test plan
- **Reset**: assert `reset` mid-cycle → all outputs take reset values immediately (`empty`=1, `count`=0, `tx_start`=0, `tx_din`=0x00).
- **Single byte**: write 0xA5 at edge N → `tx_start`=1, `tx_din`=0xA5 after N+1, `count` back to 0. A second `tx_start` never appears; pulse `tx_done_tick` → FSM returns to IDLE.
- **Fill and overflow**: hold `tx_done_tick`=0, write 0x00..0x10 (17 bytes) back-to-back → 0x00 launched. `full`=1 after 17 accepted-or-popped updates with `count`=16. The 18th write (0x11) pulses `overflow` and leaves `count`=16.
- **Drain and wrap**: from the state above, pulse `tx_done_tick` 16 times at 5-cycle spacing → `tx_din` sequence is 0x01..0x10 in order, `wp`/`rp` have wrapped, and the final `empty`=1.
- **Simultaneous write and pop**: `count`=3 and FSM in IDLE, write 0x5A in the pop cycle → `count` stays 3, and 0x5A is emitted after the earlier bytes.
- **Reset during BUSY**: 4 bytes queued, one launched; assert `reset`, then release and pulse `tx_done_tick` → no `tx_start` occurs, and `count` stays 0.
